// File: rtl/npu_sram_stream_reader_if.sv
// SRAM port-2 read bus and output word stream
// of the NPU SRAM stream reader.
interface npu_sram_stream_reader_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
);

  logic [ADDR_W-1:0]   address2;
  logic                chipselect2;
  logic                write2;
  logic [DATA_W/8-1:0] byteenable2;
  logic                clken2;
  logic [DATA_W-1:0]   readdata2;

  logic [DATA_W-1:0]   out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;

  modport master (
    output address2,
    output chipselect2,
    output write2,
    output byteenable2,
    output clken2,
    input  readdata2,
    output out_data,
    output out_valid,
    input  out_ready,
    output out_last
  );

  modport slave (
    input  address2,
    input  chipselect2,
    input  write2,
    input  byteenable2,
    input  clken2,
    output readdata2,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_last
  );

endinterface

// File: rtl/npu_sram_stream_reader.sv
// Streams a block of SRAM words out through a small FIFO,
// issuing reads only when a FIFO slot is guaranteed.
module npu_sram_stream_reader #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  npu_sram_stream_reader_if.master bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW+1:0] DEPTH_V = (PW+2)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   rem;
  logic              inflight;
  logic              inflight_last;

  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic              fifo_last [FIFO_DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [PW:0]       count;

  logic              push;
  logic              pop;
  logic              issue;
  logic              last_issue;
  logic              accept;
  logic              zero_start;
  logic              last_pop;
  logic [PW+1:0]     level;

  assign push       = inflight;
  assign pop        = (count != '0) & bus.out_ready;
  assign last_pop   = pop & bus.out_last;
  assign accept     = (state == IDLE) & start
                    & (length != '0);
  assign zero_start = (state == IDLE) & start
                    & (length == '0);
  assign last_issue = (rem == ONE);

  // Occupancy after this cycle's pop plus the read
  // still in flight; a new read needs a free slot.
  assign level = {1'b0, count}
               - (PW+2)'(pop)
               + (PW+2)'(inflight);

  // Command sequencing and read-issue decision.
  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = ISSUE;
      end
      ISSUE: begin
        issue = (level < DEPTH_V);
        if (issue && last_issue) state_nx = DRAIN;
      end
      DRAIN: begin
        if (last_pop) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Read address and remaining-issue counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr <= '0;
      rem  <= '0;
    end else if (accept) begin
      addr <= base_addr;
      rem  <= length;
    end else if (issue) begin
      addr <= addr + 1'b1;
      rem  <= rem - ONE;
    end
  end

  // One-cycle read pipeline tag, carrying the last flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue & last_issue;
    end
  end

  // FIFO storage, written as read data returns.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wptr] <= bus.readdata2;
      fifo_last[wptr] <= inflight_last;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Done pulses after the final transfer, or right
  // after a zero-length command.
  always_ff @(posedge clk) begin
    if (reset) begin
      done <= 1'b0;
    end else begin
      done <= zero_start
            | ((state == DRAIN) & last_pop);
    end
  end

  assign busy            = (state != IDLE);

  assign bus.address2    = addr;
  assign bus.chipselect2 = issue;
  assign bus.write2      = 1'b0;
  assign bus.byteenable2 = '1;
  assign bus.clken2      = 1'b1;

  assign bus.out_valid   = (count != '0);
  assign bus.out_data    = fifo_data[rptr];
  assign bus.out_last    = (count != '0)
                         & fifo_last[rptr];

endmodule

// File: tb/tb_npu_sram_stream_reader.sv
// Scoreboard bench for the SRAM stream reader
// against an identity-content SRAM model.
module tb_npu_sram_stream_reader;

  localparam int AW = 14;
  localparam int DW = 16;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy;
  logic          done;

  npu_sram_stream_reader_if #(
    .ADDR_W(AW),
    .DATA_W(DW)
  ) ifc ();

  npu_sram_stream_reader #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .base_addr(base_addr),
    .length(length),
    .busy(busy),
    .done(done),
    .bus(ifc.master)
  );

  always #5 clk = ~clk;

  // mem[i] = i; unrelated filler when not selected.
  always @(posedge clk) begin
    if (ifc.chipselect2)
      ifc.readdata2 <= DW'(ifc.address2);
    else
      ifc.readdata2 <= 16'hDEAD;
  end

  exp_t          q[$];
  int            total = 0;
  int            bad = 0;
  int            done_cnt = 0;
  int            cs_cnt = 0;
  int            outstanding = 0;
  logic          rand_ready = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_d;
  logic          prev_l;

  // Scoreboard: every transfer popped against the queue.
  always @(negedge clk) begin
    logic p;
    int   lvl;
    exp_t e;
    if (reset) begin
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      p = ifc.out_valid & ifc.out_ready;
      if (done) done_cnt++;
      if (ifc.chipselect2) cs_cnt++;
      if (prev_stall && ifc.out_valid) begin
        total++;
        if ({ifc.out_data, ifc.out_last}
            !== {prev_d, prev_l}) begin
          bad++;
          $display("FAIL stall_hold got=%h/%b exp=%h/%b",
                   ifc.out_data, ifc.out_last,
                   prev_d, prev_l);
        end
      end
      if (p) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL extra_word got=%h exp=none",
                   ifc.out_data);
        end else begin
          e = q.pop_front();
          if (ifc.out_data !== e.d ||
              ifc.out_last !== e.l) begin
            bad++;
            $display("FAIL word got=%h/%b exp=%h/%b",
                     ifc.out_data, ifc.out_last,
                     e.d, e.l);
          end
        end
      end
      lvl = outstanding + int'(ifc.chipselect2)
          - int'(p);
      if (ifc.chipselect2) begin
        total++;
        if (lvl > 4) begin
          bad++;
          $display("FAIL occupancy got=%0d exp<=4", lvl);
        end
      end
      outstanding = lvl;
      prev_stall  = ifc.out_valid & ~ifc.out_ready;
      prev_d      = ifc.out_data;
      prev_l      = ifc.out_last;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    ifc.out_ready = rand_ready
                  ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic cmd(input logic [AW-1:0] b,
                     input int n, input bit exp);
    exp_t e;
    if (exp) begin
      for (int k = 0; k < n; k++) begin
        e.d = DW'(AW'(b + AW'(k)));
        e.l = (k == n - 1);
        q.push_back(e);
      end
    end
    base_addr = b;
    length    = (AW+1)'(n);
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    total++;
    if ({busy, done, ifc.chipselect2, ifc.out_valid,
         ifc.out_last} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=00000",
               {busy, done, ifc.chipselect2,
                ifc.out_valid, ifc.out_last});
    end
    total++;
    if (ifc.address2 !== '0) begin
      bad++;
      $display("FAIL reset_addr got=%h exp=0",
               ifc.address2);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int d0 = done_cnt;
    int n = 0;
    bit ok;
    rand_ready = 1'b0;
    cmd(14'h0010, 8, 1'b1);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_start got=%b exp=1", busy);
    end
    while (!ifc.out_valid && n < 10) begin
      step();
      n++;
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (ifc.out_valid !== 1'b1) begin
        bad++;
        $display("FAIL throughput i=%0d got=0 exp=1", i);
      end
      step();
    end
    wait_done(20, ok);
    step();
    total++;
    if (!ok || done_cnt - d0 != 1 || q.size() != 0) begin
      bad++;
      $display("FAIL basic_done got=%0d/%0d exp=1/0",
               done_cnt - d0, q.size());
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_end got=%b exp=0", busy);
    end
  endtask

  task automatic test_wrap();
    int d0 = done_cnt;
    bit ok;
    cmd(14'h3FFE, 4, 1'b1);
    wait_done(30, ok);
    total++;
    if (!ok || done_cnt - d0 != 1 || q.size() != 0) begin
      bad++;
      $display("FAIL wrap got=%0d/%0d exp=1/0",
               done_cnt - d0, q.size());
    end
  endtask

  task automatic test_random_ready();
    int d0 = done_cnt;
    bit ok;
    rand_ready = 1'b1;
    cmd(14'h0100, 32, 1'b1);
    wait_done(600, ok);
    rand_ready = 1'b0;
    step();
    total++;
    if (!ok || done_cnt - d0 != 1 || q.size() != 0) begin
      bad++;
      $display("FAIL random got=%0d/%0d exp=1/0",
               done_cnt - d0, q.size());
    end
  endtask

  task automatic test_zero_length();
    int d0 = done_cnt;
    int c0 = cs_cnt;
    cmd(14'h0040, 0, 1'b0);
    total++;
    if ({done, busy} !== 2'b10) begin
      bad++;
      $display("FAIL zero_pulse got=%b exp=10",
               {done, busy});
    end
    step();
    total++;
    if ({done, busy} !== 2'b00) begin
      bad++;
      $display("FAIL zero_after got=%b exp=00",
               {done, busy});
    end
    step();
    total++;
    if (done_cnt - d0 != 1 || cs_cnt != c0) begin
      bad++;
      $display("FAIL zero_count got=%0d/%0d exp=1/0",
               done_cnt - d0, cs_cnt - c0);
    end
  endtask

  task automatic test_reset_mid();
    int d0 = done_cnt;
    bit ok;
    cmd(14'h0200, 100, 1'b1);
    repeat (20) step();
    reset = 1'b1;
    step();
    total++;
    if ({busy, done, ifc.chipselect2, ifc.out_valid,
         ifc.out_last} !== 5'b0 ||
        ifc.address2 !== '0) begin
      bad++;
      $display("FAIL mid_reset got=%b/%h exp=0/0",
               {busy, done, ifc.chipselect2,
                ifc.out_valid, ifc.out_last},
               ifc.address2);
    end
    q.delete();
    reset = 1'b0;
    step();
    cmd(14'h0050, 2, 1'b1);
    wait_done(20, ok);
    step();
    total++;
    if (!ok || done_cnt - d0 != 1 || q.size() != 0) begin
      bad++;
      $display("FAIL after_reset got=%0d/%0d exp=1/0",
               done_cnt - d0, q.size());
    end
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    bit ok;
    cmd(14'h0300, 6, 1'b1);
    step();
    cmd(14'h0400, 3, 1'b0);
    wait_done(30, ok);
    repeat (8) step();
    total++;
    if (!ok || done_cnt - d0 != 1 || q.size() != 0) begin
      bad++;
      $display("FAIL ignore_start got=%0d/%0d exp=1/0",
               done_cnt - d0, q.size());
    end
    cmd(14'h0500, 3, 1'b1);
    wait_done(30, ok);
    step();
    total++;
    if (!ok || done_cnt - d0 != 2 || q.size() != 0) begin
      bad++;
      $display("FAIL second_cmd got=%0d/%0d exp=2/0",
               done_cnt - d0, q.size());
    end
  endtask

  initial begin
    reset         = 1'b1;
    start         = 1'b0;
    base_addr     = '0;
    length        = '0;
    ifc.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_random_ready();
    test_zero_length();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
